sphere_table: RTL and testbench

- Double-buffered scene store holding up to N_SPHERES sphere records (position, radius, colour) for the ray-tracing pipeline.
- The MCU-facing link streams a new scene as 16-bit words into the shadow bank.
- The shadow bank becomes the active bank only on a frame-sync pulse, so a frame never mixes two scenes.
- The tracer reads records from the active bank by index, with 1-cycle latency.

---
 rtl/sphere_table_pkg.sv | 34 +++
 rtl/sphere_word_assembler.sv | 49 ++++
 rtl/sphere_table.sv | 159 +++++++++++++++
 tb/tb_sphere_table.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sphere_table_pkg.sv
// Shared types and width helpers for the double-buffered sphere scene store.
package sphere_table_pkg;

  localparam int unsigned DefNSpheres = 8;
  localparam int unsigned DefXW       = 16;
  localparam int unsigned DefYW       = 14;
  localparam int unsigned DefZW       = 16;
  localparam int unsigned DefRW       = 6;
  localparam int unsigned DefCW       = 12;
  localparam int unsigned DefWordW    = 16;
  localparam int unsigned DefSphW     = DefXW + DefYW + DefZW + DefRW + DefCW;

  typedef struct packed {
    logic [DefCW/3-1:0] r;
    logic [DefCW/3-1:0] g;
    logic [DefCW/3-1:0] b;
  } color_t;

  typedef struct packed {
    logic signed [DefXW-1:0] x;
    logic signed [DefYW-1:0] y;
    logic signed [DefZW-1:0] z;
    logic        [DefRW-1:0] r;
    color_t                  c;
  } sphere_t;

  typedef enum logic [1:0] {StIdle, StLoad, StDrop, StPending} load_state_e;

  function automatic int unsigned words_per_sphere(input int unsigned sph_w,
                                                   input int unsigned word_w);
    return (sph_w + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/sphere_word_assembler.sv
// Collects MSB-first load words into one sphere record; rec_valid marks the
// cycle in which the final word of a record is being shifted in.
module sphere_word_assembler
  import sphere_table_pkg::*;
#(
  parameter int unsigned SPH_W  = DefSphW,
  parameter int unsigned WORD_W = DefWordW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift,
  input  logic [WORD_W-1:0] word,
  output logic              rec_valid,
  output logic [SPH_W-1:0]  record
);

  localparam int unsigned WPS  = words_per_sphere(SPH_W, WORD_W);
  localparam int unsigned CN_W = (WPS > 1) ? $clog2(WPS) : 1;

  logic [SPH_W-1:0] shreg_q;
  logic [CN_W-1:0]  cnt_q, cnt_d;
  logic             last;

  // Pad bits of the first word fall off the top of the truncation.
  assign record    = SPH_W'({shreg_q, word});
  assign last      = (cnt_q == CN_W'(WPS - 1));
  assign rec_valid = shift & last;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (shift) begin
      cnt_d = last ? '0 : cnt_q + CN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (shift && !clear) shreg_q <= record;
    end
  end

endmodule

// File: rtl/sphere_table.sv
// Double-buffered sphere table: scenes stream into the shadow bank and become
// visible to the tracer only when a frame_sync swaps the banks.
module sphere_table
  import sphere_table_pkg::*;
#(
  parameter int unsigned N_SPHERES = DefNSpheres,
  parameter int unsigned X_W       = DefXW,
  parameter int unsigned Y_W       = DefYW,
  parameter int unsigned Z_W       = DefZW,
  parameter int unsigned R_W       = DefRW,
  parameter int unsigned C_W       = DefCW,
  parameter int unsigned WORD_W    = DefWordW,
  localparam int unsigned SPH_W    = X_W + Y_W + Z_W + R_W + C_W,
  localparam int unsigned IDX_W    = (N_SPHERES > 1) ? $clog2(N_SPHERES) : 1,
  localparam int unsigned CNT_W    = $clog2(N_SPHERES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              wr_sof,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              frame_sync,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [SPH_W-1:0]  rd_sphere,
  output logic [CNT_W-1:0]  rd_count,
  output logic              swap_pulse,
  output logic              load_err,
  output logic              pending
);

  localparam int unsigned AW = $clog2(2 * N_SPHERES);

  load_state_e      state_q, state_d;
  logic             bank_q, bank_d;
  logic [CNT_W-1:0] act_cnt_q, act_cnt_d;
  logic [CNT_W-1:0] shd_cnt_q, shd_cnt_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             swap_q, swap_d;
  logic             err_q, err_d;
  logic [SPH_W-1:0] rd_sphere_q;

  logic [SPH_W-1:0] mem [2*N_SPHERES];

  logic             accept, hdr_bad, asm_clear, asm_shift, rec_valid, mem_we;
  logic [CNT_W-1:0] hdr_n;
  logic [SPH_W-1:0] asm_record;
  logic [AW-1:0]    waddr, raddr;

  assign wr_ready  = (state_q != StPending);
  assign accept    = wr_valid & wr_ready;
  assign hdr_n     = wr_data[CNT_W-1:0];
  assign hdr_bad   = (|(wr_data >> CNT_W)) || (hdr_n > CNT_W'(N_SPHERES));
  assign asm_clear = accept & wr_sof;
  assign asm_shift = accept & ~wr_sof & (state_q == StLoad);

  sphere_word_assembler #(
    .SPH_W  (SPH_W),
    .WORD_W (WORD_W)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (asm_clear),
    .shift     (asm_shift),
    .word      (wr_data),
    .rec_valid (rec_valid),
    .record    (asm_record)
  );

  always_comb begin
    state_d   = state_q;
    bank_d    = bank_q;
    act_cnt_d = act_cnt_q;
    shd_cnt_d = shd_cnt_q;
    tgt_d     = tgt_q;
    idx_d     = idx_q;
    swap_d    = 1'b0;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    unique case (state_q)
      StIdle, StLoad, StDrop: begin
        if (accept && wr_sof) begin
          // A header mid-load aborts the partial scene and restarts at once.
          idx_d = '0;
          if (state_q == StLoad) err_d = 1'b1;
          if (hdr_bad) begin
            err_d   = 1'b1;
            state_d = StDrop;
          end else if (hdr_n == '0) begin
            shd_cnt_d = '0;
            state_d   = StPending;
          end else begin
            tgt_d   = hdr_n;
            state_d = StLoad;
          end
        end else if (accept && state_q == StIdle) begin
          err_d = 1'b1;
        end else if (asm_shift && rec_valid) begin
          mem_we = 1'b1;
          idx_d  = idx_q + CNT_W'(1);
          if (idx_d == tgt_q) begin
            shd_cnt_d = tgt_q;
            state_d   = StPending;
          end
        end
      end
      StPending: begin
        if (frame_sync) begin
          bank_d    = ~bank_q;
          act_cnt_d = shd_cnt_q;
          swap_d    = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Bank 0 occupies [0, N), bank 1 occupies [N, 2N); writes target the shadow bank.
  assign waddr = bank_q ? AW'(idx_q) : AW'(idx_q) + AW'(N_SPHERES);
  // Reading through bank_d makes the new bank visible alongside swap_pulse.
  assign raddr = bank_d ? AW'(rd_idx) + AW'(N_SPHERES) : AW'(rd_idx);

  always_ff @(posedge clk) begin
    if (mem_we) mem[waddr] <= asm_record;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      bank_q      <= 1'b0;
      act_cnt_q   <= '0;
      shd_cnt_q   <= '0;
      tgt_q       <= '0;
      idx_q       <= '0;
      swap_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_sphere_q <= '0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      act_cnt_q   <= act_cnt_d;
      shd_cnt_q   <= shd_cnt_d;
      tgt_q       <= tgt_d;
      idx_q       <= idx_d;
      swap_q      <= swap_d;
      err_q       <= err_d;
      rd_sphere_q <= mem[raddr];
    end
  end

  assign rd_sphere  = rd_sphere_q;
  assign rd_count   = act_cnt_q;
  assign swap_pulse = swap_q;
  assign load_err   = err_q;
  assign pending    = (state_q == StPending);

endmodule

// File: tb/tb_sphere_table.sv
// Self-checking bench for sphere_table: directed vector table, corner-case
// sequences and a randomized run against a scene-level reference model.
module tb_sphere_table;
  import sphere_table_pkg::*;

  localparam int N   = 8;
  localparam int WPS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0, wr_sof = 1'b0, frame_sync = 1'b0;
  logic [15:0] wr_data = '0;
  logic [2:0]  rd_idx = '0;
  logic        wr_ready, swap_pulse, load_err, pending;
  logic [63:0] rd_sphere;
  logic [3:0]  rd_count;

  always #5 clk = ~clk;

  sphere_table dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_sof     (wr_sof),
    .wr_data    (wr_data),
    .frame_sync (frame_sync),
    .rd_idx     (rd_idx),
    .rd_sphere  (rd_sphere),
    .rd_count   (rd_count),
    .swap_pulse (swap_pulse),
    .load_err   (load_err),
    .pending    (pending)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Scene-level model: 0 idle, 1 loading, 2 dropping, 3 waiting for frame_sync.
  int          m_mode, m_need, m_act_cnt, m_sh_cnt;
  logic [15:0] m_words[$];
  logic [63:0] m_act[N], m_sh[N];
  bit          e_err, e_swap;

  typedef struct {
    bit          v, sof;
    logic [15:0] d;
    bit          fs;
    logic [2:0]  idx;
    bit          e_rdy, e_pend, e_swap, e_err;
    logic [3:0]  e_cnt;
    bit          chk_sph;
    logic [63:0] e_sph;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_need = 0; m_act_cnt = 0; m_sh_cnt = 0;
    m_words.delete();
    e_err = 0; e_swap = 0;
  endtask

  task automatic model_step(input bit v, input bit sof, input logic [15:0] d, input bit fs);
    logic [63:0] r;
    e_err = 0; e_swap = 0;
    if (m_mode == 3) begin
      if (fs) begin
        m_act = m_sh; m_act_cnt = m_sh_cnt; e_swap = 1; m_mode = 0;
      end
    end else if (v) begin
      if (sof) begin
        if (m_mode == 1) e_err = 1;
        m_words.delete();
        if (d > N) begin e_err = 1; m_mode = 2; end
        else if (d == 0) begin m_sh_cnt = 0; m_mode = 3; end
        else begin m_need = int'(d); m_mode = 1; end
      end else if (m_mode == 0) begin
        e_err = 1;
      end else if (m_mode == 1) begin
        m_words.push_back(d);
        if (m_words.size() == m_need * WPS) begin
          for (int s = 0; s < m_need; s++) begin
            r = '0;
            for (int w = 0; w < WPS; w++) r = (r << 16) | 64'(m_words[s*WPS+w]);
            m_sh[s] = r;
          end
          m_sh_cnt = m_need; m_mode = 3;
        end
      end
    end
  endtask

  task automatic apply(input bit v, input bit sof, input logic [15:0] d, input bit fs,
                       input logic [2:0] idx);
    wr_valid = v; wr_sof = sof; wr_data = d; frame_sync = fs; rd_idx = idx;
    @(posedge clk);
    #1;
    model_step(v, sof, d, fs);
    wr_valid = 1'b0; wr_sof = 1'b0; frame_sync = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".wr_ready"}, wr_ready, (m_mode != 3));
    chk({tag, ".pending"}, pending, (m_mode == 3));
    chk({tag, ".swap_pulse"}, swap_pulse, e_swap);
    chk({tag, ".load_err"}, load_err, e_err);
    chk({tag, ".rd_count"}, rd_count, 64'(m_act_cnt));
    if (int'(rd_idx) < m_act_cnt) chk({tag, ".rd_sphere"}, rd_sphere, m_act[rd_idx]);
  endtask

  task automatic go(input string tag, input bit v, input bit sof, input logic [15:0] d,
                    input bit fs, input logic [2:0] idx);
    apply(v, sof, d, fs, idx);
    check_model(tag);
  endtask

  task automatic do_reset(input string tag);
    #1 rst = 1'b1;
    wr_valid = 1'b0; wr_sof = 1'b0; frame_sync = 1'b0;
    #2;
    chk({tag, ".rst_ready"}, wr_ready, 1);
    chk({tag, ".rst_pending"}, pending, 0);
    chk({tag, ".rst_count"}, rd_count, 0);
    chk({tag, ".rst_swap"}, swap_pulse, 0);
    chk({tag, ".rst_err"}, load_err, 0);
    chk({tag, ".rst_sphere"}, rd_sphere, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  function automatic vec_t mk(bit v, bit sof, logic [15:0] d, bit fs, logic [2:0] idx,
                              bit rdy, bit pend, bit sw, bit er, logic [3:0] cnt,
                              bit cs, logic [63:0] sph);
    vec_t t;
    t.v = v; t.sof = sof; t.d = d; t.fs = fs; t.idx = idx;
    t.e_rdy = rdy; t.e_pend = pend; t.e_swap = sw; t.e_err = er; t.e_cnt = cnt;
    t.chk_sph = cs; t.e_sph = sph;
    return t;
  endfunction

  localparam logic [63:0] Rec0 = 64'h0001_0002_0003_0004;
  localparam logic [63:0] Rec1 = 64'h0005_0006_0007_0008;

  initial begin
    model_reset();
    // Directed table: n=2 scene, swap, bad header n=9 with dropped payload.
    tbl.push_back(mk(1, 1, 16'd2, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 7; k++) tbl.push_back(mk(1, 0, 16'(k), 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 16'd8, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 16'd0, 1, 0, 1, 0, 1, 0, 2, 1, Rec0));
    tbl.push_back(mk(0, 0, 16'd0, 0, 1, 1, 0, 0, 0, 2, 1, Rec1));
    tbl.push_back(mk(1, 1, 16'd9, 0, 1, 1, 0, 0, 1, 2, 1, Rec1));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(1, 0, 16'hAAAA, 0, 1, 1, 0, 0, 0, 2, 1, Rec1));
    tbl.push_back(mk(0, 0, 16'd0, 1, 0, 1, 0, 0, 0, 2, 1, Rec0));

    repeat (2) @(posedge clk);
    #3;
    chk("init.rd_sphere", rd_sphere, 0);
    chk("init.wr_ready", wr_ready, 1);
    chk("init.rd_count", rd_count, 0);
    #1 rst = 1'b0;

    foreach (tbl[i]) begin
      apply(tbl[i].v, tbl[i].sof, tbl[i].d, tbl[i].fs, tbl[i].idx);
      chk($sformatf("tbl%0d.wr_ready", i), wr_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d.pending", i), pending, tbl[i].e_pend);
      chk($sformatf("tbl%0d.swap_pulse", i), swap_pulse, tbl[i].e_swap);
      chk($sformatf("tbl%0d.load_err", i), load_err, tbl[i].e_err);
      chk($sformatf("tbl%0d.rd_count", i), rd_count, tbl[i].e_cnt);
      if (tbl[i].chk_sph) chk($sformatf("tbl%0d.rd_sphere", i), rd_sphere, tbl[i].e_sph);
    end

    // Header mid-load aborts the first scene; only the second becomes active.
    go("abort.hdr", 1, 1, 16'd3, 0, 0);
    for (int k = 0; k < 6; k++) go("abort.pay", 1, 0, 16'($urandom), 0, 0);
    go("abort.sof2", 1, 1, 16'd1, 0, 0);
    chk("abort.load_err", load_err, 1);
    for (int k = 0; k < 4; k++) go("abort.pay2", 1, 0, 16'($urandom), 0, 0);
    go("abort.fs", 0, 0, 16'd0, 1, 0);
    chk("abort.rd_count", rd_count, 1);

    // frame_sync coinciding with the final word must not swap.
    go("late.hdr", 1, 1, 16'd1, 0, 0);
    for (int k = 0; k < 3; k++) go("late.pay", 1, 0, 16'($urandom), 0, 0);
    go("late.last", 1, 0, 16'h1234, 1, 0);
    chk("late.no_swap", swap_pulse, 0);
    chk("late.pending", pending, 1);
    go("late.fs", 0, 0, 16'd0, 1, 0);
    chk("late.swap", swap_pulse, 1);

    // Two-sphere scene active; while the next scene waits, reads stay on old bank.
    go("hold.hdr", 1, 1, 16'd2, 0, 0);
    for (int k = 0; k < 8; k++) go("hold.pay", 1, 0, 16'($urandom), 0, 1);
    go("hold.fs", 0, 0, 16'd0, 1, 1);
    go("hold.hdr2", 1, 1, 16'd2, 0, 1);
    for (int k = 0; k < 8; k++) go("hold.pay2", 1, 0, 16'($urandom), 0, 1);
    for (int k = 0; k < 3; k++) go("hold.blocked", 1, 0, 16'hDEAD, 0, 3'(k % 2));
    chk("hold.wr_ready", wr_ready, 0);
    go("hold.fs2", 0, 0, 16'd0, 1, 0);

    // Reset mid-load discards the partial scene.
    go("rml.hdr", 1, 1, 16'd8, 0, 0);
    for (int k = 0; k < 3; k++) go("rml.pay", 1, 0, 16'($urandom), 0, 0);
    do_reset("rml");
    go("rml.n0", 1, 1, 16'd0, 0, 0);
    chk("rml.pending", pending, 1);
    go("rml.fs", 0, 0, 16'd0, 1, 0);
    chk("rml.swap", swap_pulse, 1);
    chk("rml.rd_count", rd_count, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit          v, sof, fs;
      logic [15:0] d;
      int          r;
      v   = ($urandom_range(0, 99) < 75);
      sof = ($urandom_range(0, 99) < 6);
      fs  = ($urandom_range(0, 99) < 12);
      d   = 16'($urandom);
      if (sof) begin
        r = int'($urandom_range(0, 19));
        if (r < 10) d = 16'(r);
        else if (r < 12) d = 16'h0010 << $urandom_range(0, 11) | 16'($urandom_range(0, 8));
        else d = 16'($urandom_range(1, 3));
      end
      go($sformatf("rnd%0d", i), v, sof, d, fs, 3'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
